// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers host writes, launches one frame
// at a time with tx_start/tx_data held until the transmitter's done pulse arrives.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_en,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_done,
    output logic [15:0]   frames_sent
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [15:0]   frames_q, frames_d;
    logic          done_s1_q, done_s1_d, done_s2_q, done_s2_d, done_prev_q, done_prev_d;
    logic          done_rise, pop, wr_accept;

    assign full        = (count_q == (AW+1)'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign frames_sent = frames_q;

    // tx_done comes from the tx_clk domain; only the synchronized copy is used.
    assign done_rise = done_s2_q & ~done_prev_q;

    always_comb begin
        state_d     = state_q;
        tx_start_d  = tx_start_q;
        tx_data_d   = tx_data_q;
        frames_d    = frames_q;
        pop         = 1'b0;
        done_s1_d   = tx_done;
        done_s2_d   = done_s1_q;
        done_prev_d = done_s2_q;
        unique case (state_q)
            IDLE: begin
                tx_start_d = 1'b0;
                if (tx_en && !empty) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                tx_start_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                if (done_rise) begin
                    tx_start_d = 1'b0;
                    frames_d   = frames_q + 16'd1;
                    state_d    = GAP;
                end
            end
            GAP: begin
                // a long done pulse must fall before the next frame may count
                if (!done_s2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_accept  = wr_en && (!full || pop);
        overflow_d = overflow_q | (wr_en & full & ~pop);
        wr_ptr_d   = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (wr_accept && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!wr_accept && pop) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            frames_q    <= 16'd0;
            done_s1_q   <= 1'b0;
            done_s2_q   <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            frames_q    <= frames_d;
            done_s1_q   <= done_s1_d;
            done_s2_q   <= done_s2_d;
            done_prev_q <= done_prev_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model answering tx_start.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tx_en = 1'b0, wr_en = 1'b0, tx_done = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        full, empty, overflow, tx_start;
    logic [4:0]  count;
    logic [7:0]  tx_data;
    logic [15:0] frames_sent;
    int          checks = 0, errors = 0;

    uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; tx_en = 1'b0; wr_en = 1'b0; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 1; i <= 16; i++) wr_byte(8'(i));
    endtask

    // Transmitter model: accept frame, hold for a while, pulse tx_done.
    task automatic send_frame(input logic [7:0] exp);
        int n = 0;
        while (!tx_start && n < 100) begin @(negedge clk); n++; end
        chk("tx_start_seen", {31'd0, tx_start}, 1);
        chk("tx_data", {24'd0, tx_data}, {24'd0, exp});
        repeat (20) @(negedge clk);
        chk("tx_data_hold", {24'd0, tx_data}, {24'd0, exp});
        tx_done = 1'b1;
        n = 0;
        while (tx_start && n < 8) begin @(negedge clk); n++; end
        chk("stop_latency", n, 3);
        repeat (2) @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin
        int n;
        do_reset();
        chk("rst_empty", {31'd0, empty}, 1);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_count", {27'd0, count}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_tx_start", {31'd0, tx_start}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_frames", {16'd0, frames_sent}, 0);

        // single byte, latency
        tx_en = 1'b1;
        wr_byte(8'hA5);
        chk("lat_c1_start", {31'd0, tx_start}, 0);
        @(negedge clk);
        chk("lat_c2_start", {31'd0, tx_start}, 0);
        chk("lat_c2_data", {24'd0, tx_data}, 32'hA5);
        @(negedge clk);
        chk("lat_c3_start", {31'd0, tx_start}, 1);
        send_frame(8'hA5);
        chk("single_frames", {16'd0, frames_sent}, 1);
        chk("single_empty", {31'd0, empty}, 1);

        // burst + overflow
        do_reset();
        fill16();
        chk("burst_full", {31'd0, full}, 1);
        chk("burst_count", {27'd0, count}, 16);
        chk("burst_ovf0", {31'd0, overflow}, 0);
        wr_byte(8'hFF);
        chk("ovf_set", {31'd0, overflow}, 1);
        chk("ovf_count", {27'd0, count}, 16);
        tx_en = 1'b1;
        for (int i = 1; i <= 16; i++) send_frame(8'(i));
        chk("burst_frames", {16'd0, frames_sent}, 16);
        chk("burst_empty", {31'd0, empty}, 1);
        repeat (30) @(negedge clk);
        chk("ovf_ff_not_sent", {31'd0, tx_start}, 0);
        chk("ovf_sticky", {31'd0, overflow}, 1);

        // simultaneous write and pop while full
        do_reset();
        fill16();
        tx_en = 1'b1;
        wr_byte(8'h77);
        chk("simul_count", {27'd0, count}, 16);
        chk("simul_ovf", {31'd0, overflow}, 0);
        chk("simul_data", {24'd0, tx_data}, 1);
        for (int i = 1; i <= 16; i++) send_frame(8'(i));
        send_frame(8'h77);
        chk("simul_frames", {16'd0, frames_sent}, 17);
        chk("simul_empty", {31'd0, empty}, 1);

        // long tx_done held 500 clk
        do_reset();
        tx_en = 1'b1;
        wr_byte(8'h3C);
        n = 0;
        while (!tx_start && n < 100) begin @(negedge clk); n++; end
        chk("long_start", {31'd0, tx_start}, 1);
        repeat (10) @(negedge clk);
        tx_done = 1'b1;
        repeat (10) @(negedge clk);
        wr_byte(8'h5A);
        repeat (489) @(negedge clk);
        chk("long_frames", {16'd0, frames_sent}, 1);
        chk("long_no_restart", {31'd0, tx_start}, 0);
        chk("long_count", {27'd0, count}, 1);
        tx_done = 1'b0;
        send_frame(8'h5A);
        chk("long_frames2", {16'd0, frames_sent}, 2);

        // reset mid-frame with 5 bytes queued
        tx_en = 1'b0;
        for (int i = 0; i < 6; i++) wr_byte(8'h40 + 8'(i));
        tx_en = 1'b1;
        n = 0;
        while (!tx_start && n < 100) begin @(negedge clk); n++; end
        chk("mid_count_q", {27'd0, count}, 5);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_async_start", {31'd0, tx_start}, 0);
        chk("mid_count", {27'd0, count}, 0);
        chk("mid_frames", {16'd0, frames_sent}, 0);
        chk("mid_empty", {31'd0, empty}, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        chk("mid_no_frame", {31'd0, tx_start}, 0);
        wr_byte(8'h99);
        send_frame(8'h99);
        chk("mid_new_frame", {16'd0, frames_sent}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
